// File: rtl/selector_2.sv
// selector_2: registered two-way data selector with capture enable.
// Output loads Input0 or Input1 on a rising clk when En=1; Valid pulses for
// one cycle after each capture. Optional build macro SELECTOR_2_SEL_CHECK_EN
// turns out-of-range Sel values into a zero capture plus a sticky Err flag.
// Without the macro only the select LSB is decoded and Err is tied low.
module selector_2 #(
  parameter int bits     = 16,
  parameter int sel_bits = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [bits-1:0]     Input0,
  input  logic [bits-1:0]     Input1,
  input  logic [sel_bits-1:0] Sel,
  input  logic                En,
  output logic [bits-1:0]     Output,
  output logic                Valid,
  output logic                Err
);

  logic [bits-1:0] sel_data;

`ifdef SELECTOR_2_SEL_CHECK_EN
  logic sel_bad;
  logic err_q;

  assign sel_bad = (Sel > sel_bits'(1));

  // Decode the full select; anything past index 1 yields zero, never X.
  always_comb begin
    sel_data = '0;
    if (Sel == '0) begin
      sel_data = Input0;
    end else if (Sel == sel_bits'(1)) begin
      sel_data = Input1;
    end
  end

  // Sticky error: set by any capture with an out-of-range select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (En && sel_bad) begin
      err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  logic sel_odd;

  // Mask against the whole select so upper bits are deliberately ignored.
  assign sel_odd = ((Sel & sel_bits'(1)) != '0);

  // Only the select LSB picks the candidate in this build.
  always_comb begin
    sel_data = sel_odd ? Input1 : Input0;
  end

  assign Err = 1'b0;
`endif

  // Output register and capture strobe; Output holds when En is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Output <= '0;
      Valid  <= 1'b0;
    end else begin
      Valid <= En;
      if (En) begin
        Output <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_selector_2.sv
// Testbench for selector_2: directed scenarios followed by randomized
// traffic, checked against a behavioural model of the selection rules.
module tb_selector_2;

  logic        clk;
  logic        reset;
  logic [15:0] in0, in1;
  logic [3:0]  sel;
  logic        en;
  logic [15:0] out;
  logic        valid, err;

  logic [7:0]  in0_8, in1_8;
  logic [3:0]  sel_8;
  logic        en_8;
  logic [7:0]  out_8;
  logic        valid_8, err_8;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [15:0] m_out;
  logic        m_valid, m_err;
  logic [7:0]  m8_out;
  logic        m8_valid, m8_err;

  selector_2 dut (
    .clk(clk), .reset(reset), .Input0(in0), .Input1(in1), .Sel(sel),
    .En(en), .Output(out), .Valid(valid), .Err(err)
  );

  selector_2 #(.bits(8), .sel_bits(4)) dut8 (
    .clk(clk), .reset(reset), .Input0(in0_8), .Input1(in1_8), .Sel(sel_8),
    .En(en_8), .Output(out_8), .Valid(valid_8), .Err(err_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selection rule: index 0/1 picks a candidate; larger indices either
  // produce zero with an error (checked build) or fold onto index parity.
  task automatic pick(input logic [31:0] a, input logic [31:0] b, input int s,
                      output logic [31:0] o, output logic bad);
    logic [31:0] cand [2];
    cand[0] = a;
    cand[1] = b;
    bad = 1'b0;
`ifdef SELECTOR_2_SEL_CHECK_EN
    if (s >= 2) begin
      o   = 32'd0;
      bad = 1'b1;
    end else begin
      o = cand[s];
    end
`else
    o = cand[s % 2];
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},    {16'd0, out},     {16'd0, m_out});
    check({tag, ".valid"},  {31'd0, valid},   {31'd0, m_valid});
    check({tag, ".err"},    {31'd0, err},     {31'd0, m_err});
    check({tag, ".out8"},   {24'd0, out_8},   {24'd0, m8_out});
    check({tag, ".valid8"}, {31'd0, valid_8}, {31'd0, m8_valid});
    check({tag, ".err8"},   {31'd0, err_8},   {31'd0, m8_err});
  endtask

  task automatic model_reset();
    m_out = '0;  m_valid = 1'b0;  m_err = 1'b0;
    m8_out = '0; m8_valid = 1'b0; m8_err = 1'b0;
  endtask

  // One rising edge: update the model from the inputs present at the edge,
  // then sample the DUTs 1 time unit later.
  task automatic tick(input string tag);
    logic [31:0] o;
    logic bad;
    @(posedge clk);
    if (!reset) begin
      m_valid = en;
      if (en) begin
        pick({16'd0, in0}, {16'd0, in1}, int'(sel), o, bad);
        m_out = o[15:0];
        if (bad) m_err = 1'b1;
      end
      m8_valid = en_8;
      if (en_8) begin
        pick({24'd0, in0_8}, {24'd0, in1_8}, int'(sel_8), o, bad);
        m8_out = o[7:0];
        if (bad) m8_err = 1'b1;
      end
    end
    #1;
    check_all(tag);
  endtask

  // Async reset pulse placed between clock edges.
  task automatic mid_reset(input string tag);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in0 = '0; in1 = '0; sel = '0; en = 1'b0;
    in0_8 = '0; in1_8 = '0; sel_8 = '0; en_8 = 1'b0;
    model_reset();
    #2;
    check_all("reset_init");
    // Clock edges under reset are ignored even with En high
    en = 1'b1; en_8 = 1'b1; in0 = 16'h1234; in0_8 = 8'h12;
    tick("reset_hold");
    check("reset_hold_zero", {16'd0, out}, 32'd0);
    #2;
    reset = 1'b0;
    en = 1'b0; en_8 = 1'b0;

    // First capture
    in0 = 16'd1; in1 = 16'd2; sel = 4'd0; en = 1'b1;
    tick("cap_sel0");
    check("cap_sel0_const", {16'd0, out}, 32'd1);

    // One-cycle latency: new select not visible before the edge
    sel = 4'd1;
    #1;
    check("latency_before", {16'd0, out}, 32'd1);
    tick("cap_sel1");
    check("cap_sel1_const", {16'd0, out}, 32'd2);

    // Hold with En low while inputs change
    en = 1'b0; in1 = 16'hBEEF; sel = 4'd0;
    for (int i = 0; i < 3; i++) tick("hold");
    check("hold_const", {16'd0, out}, 32'd2);
    check("hold_valid", {31'd0, valid}, 32'd0);

    // Out-of-range select
    sel = 4'd5; en = 1'b1;
    tick("sel5");
    sel = 4'd0;
    tick("sel5_then0");
    tick("sel5_then0b");

    // Reset between edges with captured data present
    sel = 4'd1; in1 = 16'd2;
    tick("pre_reset");
    mid_reset("mid_reset");
    sel = 4'd0; in0 = 16'h00A5;
    tick("post_reset");
    check("post_reset_const", {16'd0, out}, 32'h00A5);

    // Narrow instance: alternating select, Output follows one edge behind
    en = 1'b0;
    in0_8 = 8'hFF; in1_8 = 8'h00; en_8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel_8 = 4'(i % 2);
      tick("alt8");
      check("alt8_const", {24'd0, out_8}, (i % 2 == 0) ? 32'hFF : 32'h00);
    end
    en_8 = 1'b0;
    tick("alt8_idle");

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      in0   = 16'($urandom);
      in1   = 16'($urandom);
      sel   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      en    = ($urandom_range(0, 3) != 0);
      in0_8 = 8'($urandom);
      in1_8 = 8'($urandom);
      sel_8 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      en_8  = ($urandom_range(0, 3) != 0);
      tick("rand");
      if ($urandom_range(0, 49) == 0) mid_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/selector_2.md
SELECTOR_2 -- requirements
Module: selector_2

Interface
REQ-001 Parameter bits, default 16, data width of each input and of Output.
REQ-002 Parameter sel_bits, default 4, width of Sel.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Input0  input  bits  data candidate for index 0.
REQ-006 Input1  input  bits  data candidate for index 1.
REQ-007 Sel  input  sel_bits  unsigned binary select index.
REQ-008 En  input  1  capture enable for the output register.
REQ-009 Output  output  bits  registered selected data.
REQ-010 Valid  output  1  high for one cycle after each capture.
REQ-011 Err  output  1  sticky out-of-range-select flag.

Function
REQ-012 Rising clk with En=1: Output SHALL load Input0 when Sel=0 and Input1 when Sel=1.
REQ-013 Latency SHALL be exactly one clock from Sel/Input sampling to Output; no combinational path from inputs to Output.
REQ-014 Rising clk with En=0: Output SHALL hold its value; Valid SHALL go to 0.
REQ-015 Valid SHALL be 1 in the cycle after every edge with En=1, else 0; back-to-back enables keep Valid high.
REQ-016 Out-of-range Sel (2..2**sel_bits-1) SHALL be handled per Configuration; it SHALL never produce X on Output.
REQ-017 Err SHALL be sticky: once set it stays 1 until reset.
REQ-018 Input changes while En=0 SHALL have no effect on Output, Valid or Err.
REQ-019 Width rules: Output exactly bits wide, no sign extension, no arithmetic on data.

Reset
REQ-020 reset=1 SHALL immediately, without a clock edge, force Output=0, Valid=0, Err=0.
REQ-021 While reset=1, clk edges SHALL be ignored regardless of En.
REQ-022 Reset asserted mid-operation SHALL discard any capture in progress; first capture occurs on the first rising clk with reset=0 and En=1.

Configuration
REQ-023 Macro SELECTOR_2_SEL_CHECK_EN defined: a capture with Sel>=2 SHALL load Output=0, set Valid=1 and set Err=1.
REQ-024 Macro SELECTOR_2_SEL_CHECK_EN undefined: a capture SHALL decode only Sel[0] (0 -> Input0, 1 -> Input1), upper Sel bits ignored, and Err SHALL be tied to 0.
REQ-025 Port list SHALL be identical in both builds.

Verification
REQ-026 reset pulse, then Input0=1, Input1=2, Sel=0, En=1, one edge -> Output=1, Valid=1, Err=0.
REQ-027 Continue with Sel=1, En=1, one edge -> Output=2; before that edge Output still 1 (one-cycle latency).
REQ-028 En=0, change Input1 to 0xBEEF and Sel=0, three edges -> Output holds 2, Valid=0.
REQ-029 Sel=5, En=1, one edge -> with macro: Output=0, Err=1, Err still 1 after later Sel=0 captures; without macro: Output=Input1, Err=0.
REQ-030 reset asserted between clock edges with Output=2 and Err=1 -> Output=0, Valid=0, Err=0 immediately; after release, Sel=0 capture -> Output=Input0.
REQ-031 bits=8 build: Input0=0xFF, Input1=0x00, alternate Sel 0/1 with En=1 each edge -> Output alternates 0xFF/0x00 one cycle behind Sel.
